fetch_controller: RTL and testbench
===================================

Name: fetch_controller

Overview:
- Sequencer for the MIPS instruction fetch stage.
- Owns the write side of the instruction RAM during program load, then drives PC enable/clear and IF/ID enable/flush during execution.
- Execution runs in continuous or single-step mode.
- Sits between the debug/loader unit, the hazard unit and instruction_fetch.

Parameters:
len, 32, instruction/data word width
ADDR_W, 11, instruction RAM address width (2048 words)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_load_valid  in  1  loader word valid
in_load_data  in  len  instruction word to store
in_load_last  in  1  marks final word of program
out_load_ready  out  1  controller accepts load word
in_start  in  1  begin execution (level, sampled)
in_mode  in  1  0 = continuous, 1 = single-step
in_step  in  1  step request (level; rising edge used)
in_stall  in  1  load-use stall from hazard unit
in_pc_src  in  1  branch/jump taken
in_halt_instr  in  1  HALT instruction decoded
out_mem_we  out  1  instruction RAM write enable
out_mem_waddr  out  ADDR_W  instruction RAM write address
out_mem_wdata  out  len  instruction RAM write data
out_pc_enable  out  1  PC register load enable
out_pc_clear  out  1  synchronous PC clear to 0
out_ifid_enable  out  1  IF/ID register enable
out_ifid_flush  out  1  IF/ID insert bubble
out_load_error  out  1  program overflowed RAM
out_done  out  1  program halted
out_state  out  3  current state encoding
out_cycle_count  out  32  executed cycles

Behaviour:
- States and encodings: IDLE=0, LOAD=1, READY=2, RUN=3, STEP_WAIT=4, STEP_EXEC=5, HALT=6.
- Reset (async):
  - state=IDLE.
  - Address counter, cycle count and step edge register = 0.
  - All outputs 0.
- Load handshake:
  - out_load_ready=1 in IDLE and LOAD only.
  - A word transfers on a cycle with in_load_valid && out_load_ready.
  - That cycle: out_mem_we=1, out_mem_waddr=counter, out_mem_wdata=in_load_data (combinational passthrough). Counter increments on the following edge.
- IDLE: first handshake writes address 0.
  - If in_load_last is set on that word -> READY.
  - Otherwise -> LOAD.
- LOAD: each handshake writes and increments.
  - in_load_last -> READY.
  - Counter at 2^ADDR_W-1 on a handshake without in_load_last: write the word, set out_load_error=1 (sticky until next reset/reload), go to READY. No wrap-around overwrite.
- READY:
  - out_pc_clear=1, out_pc_enable=0, out_ifid_flush=1, out_ifid_enable=0.
  - in_start=1 -> RUN if in_mode=0, else STEP_WAIT.
  - Entering RUN/STEP_WAIT clears the cycle count.
- RUN, per cycle:
  - out_pc_enable = in_pc_src | ~in_stall.
  - out_ifid_enable = ~in_stall.
  - out_ifid_flush = in_pc_src.
- Simultaneous in_pc_src and in_stall: pc_src wins. PC loads the target, IF/ID is flushed, IF/ID enable=0.
- Cycle count increments every RUN and STEP_EXEC cycle, including stalled ones; saturates at 2^32-1.
- in_halt_instr in RUN or STEP_EXEC:
  - Forces out_pc_enable=0 and out_ifid_enable=0 that cycle.
  - Next state HALT. Halt beats stall and pc_src.
- STEP_WAIT:
  - All enables/flush 0.
  - Rising edge of in_step (registered in_step previous=0, current=1) -> STEP_EXEC.
  - Holding in_step high yields exactly one step.
- STEP_EXEC: exactly one cycle with RUN output equations, then -> STEP_WAIT, or HALT if in_halt_instr.
- HALT:
  - out_done=1, all enables 0, cycle count frozen.
  - in_load_valid -> address counter=0, out_load_error cleared, process the word as in IDLE.
  - in_start does nothing.
- Load data presented in RUN/STEP/READY is not accepted (ready=0).
- in_mode is sampled only on the READY->start transition; changes mid-run are ignored.
- Reset mid-load or mid-run: immediate return to IDLE. RAM contents are not cleared.

Optional Feature:
CYCLE_COUNTER_EN:
- Defined: out_cycle_count behaves as above.
- Undefined: counter logic is omitted and out_cycle_count is tied to 0. All other behaviour is unchanged.

Test Plan:
- Load 4 words 0x20010005, 0x20020003, 0x00221820, HALT with last on the 4th -> we pulses at addr 0..3 with matching data, state=READY, out_load_error=0.
- Load 2048 words without last -> 2048 writes, addr 0..2047, out_load_error=1, state=READY, no write to addr 0 afterwards.
- Continuous run, in_stall=1 on cycles 3 and 4 -> pc_enable=0 and ifid_enable=0 on those cycles only. in_pc_src=1 together with in_stall on cycle 4 -> pc_enable=1, ifid_flush=1.
- Step mode, in_step held high 5 cycles then low, repeated 3 times -> exactly 3 STEP_EXEC cycles, out_cycle_count=3.
- in_halt_instr on RUN cycle 10 -> that cycle pc_enable=0, next cycle state=HALT, done=1, out_cycle_count=10 frozen.
- Assert reset during LOAD after 2 words -> async return to IDLE, outputs 0; new load restarts at addr 0.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns program load into instruction RAM, then drives PC/IF-ID control
// in continuous or single-step mode. Optional `CYCLE_COUNTER_EN enables the executed-cycle counter.
module fetch_controller #(
  parameter int len    = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_load_valid,
  input  logic [len-1:0]    in_load_data,
  input  logic              in_load_last,
  output logic              out_load_ready,
  input  logic              in_start,
  input  logic              in_mode,
  input  logic              in_step,
  input  logic              in_stall,
  input  logic              in_pc_src,
  input  logic              in_halt_instr,
  output logic              out_mem_we,
  output logic [ADDR_W-1:0] out_mem_waddr,
  output logic [len-1:0]    out_mem_wdata,
  output logic              out_pc_enable,
  output logic              out_pc_clear,
  output logic              out_ifid_enable,
  output logic              out_ifid_flush,
  output logic              out_load_error,
  output logic              out_done,
  output logic [2:0]        out_state,
  output logic [31:0]       out_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_READY     = 3'd2,
    S_RUN       = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_STEP_EXEC = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                step_q;

  logic                accept;
  logic [ADDR_W-1:0]   load_addr;
  logic                step_rise;
  logic                exec_cycle;

  // HALT takes a new program on valid alone; reload restarts at address 0.
  assign accept     = ~reset & in_load_valid &
                      ((state_q == S_IDLE) | (state_q == S_LOAD) | (state_q == S_HALT));
  assign load_addr  = (state_q == S_HALT) ? '0 : addr_q;
  assign step_rise  = in_step & ~step_q;
  assign exec_cycle = (state_q == S_RUN) | (state_q == S_STEP_EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      step_q  <= in_step;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (accept) begin
          err_d   = 1'b0;
          addr_d  = load_addr + ADDR_W'(1);
          state_d = in_load_last ? S_READY : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (in_load_last) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_READY;
          end else if (addr_q == '1) begin
            // RAM full: keep the last address rather than wrapping onto word 0.
            err_d   = 1'b1;
            state_d = S_READY;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
          end
        end
      end
      S_READY: begin
        if (in_start) state_d = in_mode ? S_STEP_WAIT : S_RUN;
      end
      S_RUN: begin
        if (in_halt_instr) state_d = S_HALT;
      end
      S_STEP_WAIT: begin
        if (step_rise) state_d = S_STEP_EXEC;
      end
      S_STEP_EXEC: begin
        state_d = in_halt_instr ? S_HALT : S_STEP_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_load_ready  = 1'b0;
    out_mem_we      = 1'b0;
    out_mem_waddr   = '0;
    out_mem_wdata   = '0;
    out_pc_enable   = 1'b0;
    out_pc_clear    = 1'b0;
    out_ifid_enable = 1'b0;
    out_ifid_flush  = 1'b0;

    if (!reset) begin
      out_load_ready = (state_q == S_IDLE) | (state_q == S_LOAD);
      if (state_q == S_READY) begin
        out_pc_clear   = 1'b1;
        out_ifid_flush = 1'b1;
      end
      if (exec_cycle) begin
        // Halt overrides everything; a taken branch overrides a stall for the PC only.
        out_pc_enable   = ~in_halt_instr & (in_pc_src | ~in_stall);
        out_ifid_enable = ~in_halt_instr & ~in_stall;
        out_ifid_flush  = in_pc_src;
      end
    end

    if (accept) begin
      out_mem_we    = 1'b1;
      out_mem_waddr = load_addr;
      out_mem_wdata = in_load_data;
    end
  end

  assign out_load_error = err_q;
  assign out_done       = (state_q == S_HALT);
  assign out_state      = state_q;

`ifdef CYCLE_COUNTER_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q;
    if (state_q == S_READY && in_start) begin
      cycle_d = '0;
    end else if (exec_cycle && cycle_q != '1) begin
      cycle_d = cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end

  assign out_cycle_count = cycle_q;
`else
  assign out_cycle_count = '0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, corner-case sequences,
// and randomized stimulus compared every cycle against a behavioural model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_load_valid;
  logic [31:0] in_load_data;
  logic        in_load_last;
  logic        out_load_ready;
  logic        in_start;
  logic        in_mode;
  logic        in_step;
  logic        in_stall;
  logic        in_pc_src;
  logic        in_halt_instr;
  logic        out_mem_we;
  logic [10:0] out_mem_waddr;
  logic [31:0] out_mem_wdata;
  logic        out_pc_enable;
  logic        out_pc_clear;
  logic        out_ifid_enable;
  logic        out_ifid_flush;
  logic        out_load_error;
  logic        out_done;
  logic [2:0]  out_state;
  logic [31:0] out_cycle_count;

  fetch_controller #(.len(32), .ADDR_W(11)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_load_valid  (in_load_valid),
    .in_load_data   (in_load_data),
    .in_load_last   (in_load_last),
    .out_load_ready (out_load_ready),
    .in_start       (in_start),
    .in_mode        (in_mode),
    .in_step        (in_step),
    .in_stall       (in_stall),
    .in_pc_src      (in_pc_src),
    .in_halt_instr  (in_halt_instr),
    .out_mem_we     (out_mem_we),
    .out_mem_waddr  (out_mem_waddr),
    .out_mem_wdata  (out_mem_wdata),
    .out_pc_enable  (out_pc_enable),
    .out_pc_clear   (out_pc_clear),
    .out_ifid_enable(out_ifid_enable),
    .out_ifid_flush (out_ifid_flush),
    .out_load_error (out_load_error),
    .out_done       (out_done),
    .out_state      (out_state),
    .out_cycle_count(out_cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        last;
    logic        start;
    logic        mode;
    logic        step;
    logic        stall;
    logic        pcsrc;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic        ready;
    logic        we;
    logic [10:0] waddr;
    logic [31:0] wdata;
    logic        pc_en;
    logic        pc_clr;
    logic        ifid_en;
    logic        flush;
    logic        err;
    logic        done;
    logic [2:0]  state;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: spec-level program/run status
  int     m_st;
  int     m_addr;
  bit     m_err;
  bit     m_prev_step;
  longint m_cnt;
  in_t    cur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic in_t mk_in(bit rst, bit valid, logic [31:0] data, bit last, bit start,
                                bit mode, bit step, bit stall, bit pcsrc, bit halt);
    in_t v;
    v.rst = rst; v.valid = valid; v.data = data; v.last = last; v.start = start;
    v.mode = mode; v.step = step; v.stall = stall; v.pcsrc = pcsrc; v.halt = halt;
    return v;
  endfunction

  function automatic out_t mk_out(bit ready, bit we, logic [10:0] waddr, logic [31:0] wdata,
                                  bit pc_en, bit pc_clr, bit ifid_en, bit flush, bit err,
                                  bit done, logic [2:0] state);
    out_t o;
    o.ready = ready; o.we = we; o.waddr = waddr; o.wdata = wdata; o.pc_en = pc_en;
    o.pc_clr = pc_clr; o.ifid_en = ifid_en; o.flush = flush; o.err = err; o.done = done;
    o.state = state;
    return o;
  endfunction

  function automatic in_t nop();
    return '0;
  endfunction

  function automatic out_t model_out(in_t i);
    out_t o = '0;
    bit acc, busy;
    if (i.rst) return o;
    acc  = i.valid && (m_st == 0 || m_st == 1 || m_st == 6);
    busy = (m_st == 3 || m_st == 5);
    o.ready = (m_st == 0 || m_st == 1);
    o.we    = acc;
    o.waddr = (m_st == 6) ? 11'd0 : m_addr[10:0];
    o.wdata = i.data;
    if (m_st == 2) begin
      o.pc_clr = 1'b1;
      o.flush  = 1'b1;
    end
    if (busy) begin
      o.flush   = i.pcsrc;
      o.pc_en   = !i.halt && (i.pcsrc || !i.stall);
      o.ifid_en = !i.halt && !i.stall;
    end
    o.err   = m_err;
    o.done  = (m_st == 6);
    o.state = m_st[2:0];
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_addr = 0; m_err = 0; m_prev_step = 0; m_cnt = 0;
  endtask

  task automatic model_step(in_t i);
    bit acc;
    if (i.rst) begin
      model_reset();
      return;
    end
    acc = i.valid && (m_st == 0 || m_st == 1 || m_st == 6);
    case (m_st)
      0, 6: if (acc) begin
        m_addr = 1; m_err = 0; m_st = i.last ? 2 : 1;
      end
      1: if (acc) begin
        if (i.last) begin m_addr++; m_st = 2; end
        else if (m_addr == 2047) begin m_err = 1; m_st = 2; end
        else m_addr++;
      end
      2: if (i.start) begin m_cnt = 0; m_st = i.mode ? 4 : 3; end
      3: begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        if (i.halt) m_st = 6;
      end
      4: if (i.step && !m_prev_step) m_st = 5;
      5: begin
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
        m_st = i.halt ? 6 : 4;
      end
      default: m_st = 0;
    endcase
    m_prev_step = i.step;
  endtask

  task automatic drive(in_t v);
    reset = v.rst; in_load_valid = v.valid; in_load_data = v.data; in_load_last = v.last;
    in_start = v.start; in_mode = v.mode; in_step = v.step; in_stall = v.stall;
    in_pc_src = v.pcsrc; in_halt_instr = v.halt;
  endtask

  task automatic check_outs(input string tag, input out_t e);
    chk({tag, "_ready"}, 64'(out_load_ready), 64'(e.ready));
    chk({tag, "_we"}, 64'(out_mem_we), 64'(e.we));
    if (e.we) begin
      chk({tag, "_waddr"}, 64'(out_mem_waddr), 64'(e.waddr));
      chk({tag, "_wdata"}, 64'(out_mem_wdata), 64'(e.wdata));
    end
    chk({tag, "_pc_en"}, 64'(out_pc_enable), 64'(e.pc_en));
    chk({tag, "_pc_clr"}, 64'(out_pc_clear), 64'(e.pc_clr));
    chk({tag, "_ifid_en"}, 64'(out_ifid_enable), 64'(e.ifid_en));
    chk({tag, "_flush"}, 64'(out_ifid_flush), 64'(e.flush));
    chk({tag, "_err"}, 64'(out_load_error), 64'(e.err));
    chk({tag, "_done"}, 64'(out_done), 64'(e.done));
    chk({tag, "_state"}, 64'(out_state), 64'(e.state));
  endtask

  function automatic logic [31:0] exp_count(longint c);
`ifdef CYCLE_COUNTER_EN
    return c[31:0];
`else
    return (c == c) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Drive one cycle's inputs away from the active edge and compare against the model.
  task automatic apply(in_t v);
    @(negedge clk);
    cur = v;
    drive(v);
    #1;
    check_outs("model", model_out(v));
    chk("model_count", 64'(out_cycle_count), v.rst ? 64'd0 : 64'(exp_count(m_cnt)));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_step(cur);
  endtask

  task automatic cyc(in_t v);
    apply(v);
    finish_cycle();
  endtask

  task automatic load_one_and_start(bit mode);
    in_t v;
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v = nop(); v.valid = 1; v.data = 32'hFC00_0000; v.last = 1;
    cyc(v);
    v = nop(); v.start = 1; v.mode = mode;
    cyc(v);
  endtask

  vec_t vecs[$];

  initial begin
    in_t v;
    int  steps;

    model_reset();
    drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Directed vector table: outputs observed while each row's inputs are applied
    vecs.push_back('{mk_in(1,0,32'h0,0,0,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,0)});
    vecs.push_back('{mk_in(0,1,32'h20010005,0,0,0,0,0,0,0),   mk_out(1,1,0,32'h20010005,0,0,0,0,0,0,0)});
    vecs.push_back('{mk_in(0,1,32'h20020003,0,0,0,0,0,0,0),   mk_out(1,1,1,32'h20020003,0,0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,1,32'h00221820,0,0,0,0,0,0,0),   mk_out(1,1,2,32'h00221820,0,0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,1,32'hFC000000,1,0,0,0,0,0,0),   mk_out(1,1,3,32'hFC000000,0,0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,1,32'hDEADBEEF,0,0,0,0,0,0,0),   mk_out(0,0,0,32'h0,0,1,0,1,0,0,2)});
    vecs.push_back('{mk_in(0,0,32'h0,0,1,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,1,0,1,0,0,2)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,1,0,0,0,0),          mk_out(0,0,0,32'h0,1,0,1,0,0,0,3)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,1,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,3)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,1,1,0),          mk_out(0,0,0,32'h0,1,0,0,1,0,0,3)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,1,0),          mk_out(0,0,0,32'h0,1,0,1,1,0,0,3)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,1,1),          mk_out(0,0,0,32'h0,0,0,0,1,0,0,3)});
    vecs.push_back('{mk_in(0,0,32'h0,0,1,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,1,6)});
    vecs.push_back('{mk_in(0,1,32'h12345678,0,0,0,0,0,0,0),   mk_out(0,1,0,32'h12345678,0,0,0,0,0,1,6)});
    vecs.push_back('{mk_in(0,1,32'h00000009,1,0,0,0,0,0,0),   mk_out(1,1,1,32'h00000009,0,0,0,0,0,0,1)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,1,0,1,0,0,2)});
    vecs.push_back('{mk_in(0,0,32'h0,0,1,1,0,0,0,0),          mk_out(0,0,0,32'h0,0,1,0,1,0,0,2)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,4)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,1,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,4)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,1,1,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,5)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,1,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,4)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,4)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,1,0,0,1),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,4)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,1,0,0,1),          mk_out(0,0,0,32'h0,0,0,0,0,0,0,5)});
    vecs.push_back('{mk_in(0,0,32'h0,0,0,0,0,0,0,0),          mk_out(0,0,0,32'h0,0,0,0,0,0,1,6)});

    foreach (vecs[k]) begin
      apply(vecs[k].i);
      check_outs($sformatf("vec%0d", k), vecs[k].o);
      finish_cycle();
    end

    // Overflow: 2048 words without last
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2048; i++) begin
      v = nop(); v.valid = 1; v.data = $urandom;
      apply(v);
      chk("ovf_we", 64'(out_mem_we), 64'd1);
      chk("ovf_waddr", 64'(out_mem_waddr), 64'(i));
      finish_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      v = nop(); v.valid = 1; v.data = 32'hAAAA_5555;
      apply(v);
      chk("ovf_no_rewrite", 64'(out_mem_we), 64'd0);
      chk("ovf_state", 64'(out_state), 64'd2);
      chk("ovf_err", 64'(out_load_error), 64'd1);
      finish_cycle();
    end
    apply(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("ovf_err_reset", 64'(out_load_error), 64'd0);
    finish_cycle();

    // Single step: step held high 5 cycles, three times; mode toggling ignored
    load_one_and_start(1'b1);
    steps = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 7; c++) begin
        v = nop(); v.step = (c < 5); v.mode = $urandom_range(0, 1);
        apply(v);
        if (out_state == 3'd5) steps++;
        finish_cycle();
      end
    end
    apply(nop());
    chk("step_exec_cycles", 64'(steps), 64'd3);
    chk("step_count", 64'(out_cycle_count), 64'(exp_count(3)));
    chk("step_state", 64'(out_state), 64'd4);
    finish_cycle();

    // Halt on RUN cycle 10
    load_one_and_start(1'b0);
    for (int k = 1; k <= 10; k++) begin
      v = nop(); v.halt = (k == 10);
      apply(v);
      if (k == 10) begin
        chk("halt_pc_en", 64'(out_pc_enable), 64'd0);
        chk("halt_ifid_en", 64'(out_ifid_enable), 64'd0);
      end
      finish_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      v = nop(); v.start = 1;
      apply(v);
      chk("halt_state", 64'(out_state), 64'd6);
      chk("halt_done", 64'(out_done), 64'd1);
      chk("halt_count", 64'(out_cycle_count), 64'(exp_count(10)));
      finish_cycle();
    end

    // Asynchronous reset in the middle of a load
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 2; k++) begin
      v = nop(); v.valid = 1; v.data = 32'h1000 + k;
      cyc(v);
    end
    @(negedge clk);
    v = nop(); v.valid = 1; v.data = 32'hBEEF;
    drive(v);
    #1;
    chk("pre_rst_state", 64'(out_state), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 64'(out_state), 64'd0);
    chk("async_rst_ready", 64'(out_load_ready), 64'd0);
    chk("async_rst_we", 64'(out_mem_we), 64'd0);
    chk("async_rst_pc_en", 64'(out_pc_enable), 64'd0);
    v.rst = 1;
    cur = v;
    finish_cycle();
    v = nop(); v.valid = 1; v.data = 32'hCAFE;
    apply(v);
    chk("reload_addr0", 64'(out_mem_waddr), 64'd0);
    chk("reload_we", 64'(out_mem_we), 64'd1);
    finish_cycle();

    // Randomized run against the model
    for (int k = 0; k < 4000; k++) begin
      v.rst   = ($urandom_range(0, 299) == 0);
      v.valid = ($urandom_range(0, 3) != 0);
      v.data  = $urandom;
      v.last  = ($urandom_range(0, 5) == 0);
      v.start = ($urandom_range(0, 3) == 0);
      v.mode  = $urandom_range(0, 1);
      v.step  = $urandom_range(0, 1);
      v.stall = ($urandom_range(0, 3) == 0);
      v.pcsrc = ($urandom_range(0, 3) == 0);
      v.halt  = ($urandom_range(0, 24) == 0);
      cyc(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
